// File: rtl/mcu_el2_pkg.sv
// Shared PMP types for the EL2 PMP blocks: config packet layout, addressing
// mode encodings and the access-type enum used by the sequential checker.
package mcu_el2_pkg;

  typedef enum logic [1:0] {
    READ  = 2'b00,
    WRITE = 2'b01,
    EXEC  = 2'b10
  } mcu_el2_pmp_type_t;

  localparam logic [1:0] PMP_MODE_OFF   = 2'b00;
  localparam logic [1:0] PMP_MODE_TOR   = 2'b01;
  localparam logic [1:0] PMP_MODE_NA4   = 2'b10;
  localparam logic [1:0] PMP_MODE_NAPOT = 2'b11;

  typedef struct packed {
    logic       lock;
    logic [1:0] mode;
    logic       execute;
    logic       write;
    logic       read;
  } mcu_el2_pmp_cfg_pkt_t;

endpackage

// File: rtl/mcu_el2_pmp_entry_match.sv
// Combinational match/permission evaluation of a single PMP entry against a
// captured word address, access type and privilege level.
module mcu_el2_pmp_entry_match
  import mcu_el2_pkg::*;
(
  input  mcu_el2_pmp_cfg_pkt_t cfg,
  input  logic [31:0]          addr,
  input  logic [31:0]          lo_addr,
  input  logic [31:0]          wa,
  input  logic [1:0]           req_type,
  input  logic                 req_priv,
  output logic                 match,
  output logic                 allow
);

  logic [31:0] napot_mask;
  logic        perm_bit;

  // Trailing ones of the NAPOT address (plus the first zero) mark the don't-care bits.
  assign napot_mask = addr ^ (addr + 32'd1);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and a latch is never inferred.
  always_comb begin
    match = 1'b0;
    case (cfg.mode)
      PMP_MODE_TOR:   match = (wa >= lo_addr) && (wa < addr);
      PMP_MODE_NA4:   match = (wa == addr);
      PMP_MODE_NAPOT: match = ((wa & ~napot_mask) == (addr & ~napot_mask));
      default:        match = 1'b0;
    endcase
  end

  always_comb begin
    perm_bit = 1'b0;
    case (mcu_el2_pmp_type_t'(req_type))
      READ:    perm_bit = cfg.read;
      WRITE:   perm_bit = cfg.write;
      EXEC:    perm_bit = cfg.execute;
      default: perm_bit = 1'b0;
    endcase
  end

  // The reserved access type is refused even for unlocked M-mode.
  assign allow = (req_type != 2'b11) && ((req_priv && !cfg.lock) || perm_bit);

endmodule

// File: rtl/mcu_el2_pmp_seq_chk.sv
// Sequential PMP checker: scans ENTRIES_PER_CYCLE entries per clock in priority
// order and returns allow/deny, the matching entry and a match flag.
module mcu_el2_pmp_seq_chk
  import mcu_el2_pkg::*;
#(
  parameter int PMP_ENTRIES       = 16,
  parameter int ENTRIES_PER_CYCLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  logic [1:0]           req_type,
  input  logic                 req_priv,
  input  mcu_el2_pmp_cfg_pkt_t pmp_pmpcfg  [PMP_ENTRIES],
  input  logic [31:0]          pmp_pmpaddr [PMP_ENTRIES],
  input  logic                 pmp_cfg_wr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_err,
  output logic                 rsp_match,
  output logic [5:0]           rsp_entry
);

  localparam int NGROUPS = PMP_ENTRIES / ENTRIES_PER_CYCLE;
  localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int IW      = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t      state;
  logic [GW-1:0] g;
  logic [31:0] wa;
  logic [1:0]  cur_type;
  logic        cur_priv;

  mcu_el2_pmp_cfg_pkt_t sel_cfg  [ENTRIES_PER_CYCLE];
  logic [31:0]          sel_addr [ENTRIES_PER_CYCLE];
  logic [31:0]          sel_lo   [ENTRIES_PER_CYCLE];
  logic [ENTRIES_PER_CYCLE-1:0] hit;
  logic [ENTRIES_PER_CYCLE-1:0] ok;

  logic       any_hit;
  logic       win_allow;
  logic [5:0] win_entry;

  assign req_ready = (state == IDLE);

  // Route the current group's entries (and each one's TOR lower bound) to the matchers.
  always_comb begin
    for (int j = 0; j < ENTRIES_PER_CYCLE; j++) begin
      logic [IW-1:0] idx;
      idx         = IW'(int'(g) * ENTRIES_PER_CYCLE + j);
      sel_cfg[j]  = pmp_pmpcfg[idx];
      sel_addr[j] = pmp_pmpaddr[idx];
      sel_lo[j]   = (idx == '0) ? 32'd0 : pmp_pmpaddr[idx - IW'(1)];
    end
  end

  for (genvar j = 0; j < ENTRIES_PER_CYCLE; j++) begin : g_match
    mcu_el2_pmp_entry_match u_match (
      .cfg      (sel_cfg[j]),
      .addr     (sel_addr[j]),
      .lo_addr  (sel_lo[j]),
      .wa       (wa),
      .req_type (cur_type),
      .req_priv (cur_priv),
      .match    (hit[j]),
      .allow    (ok[j])
    );
  end

  // Walk downwards so the lowest matching index is the one left standing.
  always_comb begin
    any_hit   = 1'b0;
    win_allow = 1'b0;
    win_entry = 6'd0;
    for (int j = ENTRIES_PER_CYCLE - 1; j >= 0; j--) begin
      if (hit[j]) begin
        any_hit   = 1'b1;
        win_allow = ok[j];
        win_entry = 6'(int'(g) * ENTRIES_PER_CYCLE + j);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      g         <= '0;
      wa        <= 32'd0;
      cur_type  <= 2'b00;
      cur_priv  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_match <= 1'b0;
      rsp_entry <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wa       <= {2'b00, req_addr[31:2]};
            cur_type <= req_type;
            cur_priv <= req_priv;
            g        <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (pmp_cfg_wr) begin
            g <= '0;
          end else if (any_hit) begin
            rsp_valid <= 1'b1;
            rsp_err   <= ~win_allow;
            rsp_match <= 1'b1;
            rsp_entry <= win_entry;
            state     <= RESP;
          end else if (g == GW'(NGROUPS - 1)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= ~cur_priv;
            rsp_match <= 1'b0;
            rsp_entry <= 6'd0;
            state     <= RESP;
          end else begin
            g <= g + GW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_el2_pmp_seq_chk.sv
// Directed bench for mcu_el2_pmp_seq_chk with hand-computed expectations.
module tb_mcu_el2_pmp_seq_chk;
  import mcu_el2_pkg::*;

  logic                 clk;
  logic                 rst_l;
  logic                 req_valid;
  logic                 req_ready;
  logic [31:0]          req_addr;
  logic [1:0]           req_type;
  logic                 req_priv;
  mcu_el2_pmp_cfg_pkt_t pmp_pmpcfg  [16];
  logic [31:0]          pmp_pmpaddr [16];
  logic                 pmp_cfg_wr;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_err;
  logic                 rsp_match;
  logic [5:0]           rsp_entry;

  int total = 0;
  int bad   = 0;

  mcu_el2_pmp_seq_chk #(.PMP_ENTRIES(16), .ENTRIES_PER_CYCLE(4)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_type    (req_type),
    .req_priv    (req_priv),
    .pmp_pmpcfg  (pmp_pmpcfg),
    .pmp_pmpaddr (pmp_pmpaddr),
    .pmp_cfg_wr  (pmp_cfg_wr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_err     (rsp_err),
    .rsp_match   (rsp_match),
    .rsp_entry   (rsp_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_cfg();
    for (int i = 0; i < 16; i++) begin
      pmp_pmpcfg[i]  = '{lock: 1'b0, mode: PMP_MODE_OFF, execute: 1'b0, write: 1'b0, read: 1'b0};
      pmp_pmpaddr[i] = 32'd0;
    end
  endtask

  // Issue one request; lat = edges after acceptance until rsp_valid, -1 on timeout.
  task automatic do_req(input logic [31:0] a, input logic [1:0] t, input logic p, output int lat);
    req_valid = 1'b1; req_addr = a; req_type = t; req_priv = p;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_l = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_type = 2'b00; req_priv = 1'b0;
    pmp_cfg_wr = 1'b0; rsp_ready = 1'b0;
    clear_cfg();
    #2 rst_l = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if ({rsp_err, rsp_match} !== 2'b00) begin bad++; $display("FAIL reset_err_match got=%b exp=00", {rsp_err, rsp_match}); end
    total++; if (rsp_entry !== 6'd0) begin bad++; $display("FAIL reset_entry got=%0d exp=0", rsp_entry); end
    #3 rst_l = 1'b1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_tor();
    int lat;
    clear_cfg();
    pmp_pmpcfg[0]  = '{lock: 1'b0, mode: PMP_MODE_TOR, execute: 1'b0, write: 1'b0, read: 1'b1};
    pmp_pmpaddr[0] = 32'h0000_0400;
    do_req(32'h0000_0800, 2'b00, 1'b0, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL tor_latency got=%0d exp=1", lat); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL tor_err got=%b exp=0", rsp_err); end
    total++; if (rsp_match !== 1'b1) begin bad++; $display("FAIL tor_match got=%b exp=1", rsp_match); end
    total++; if (rsp_entry !== 6'd0) begin bad++; $display("FAIL tor_entry got=%0d exp=0", rsp_entry); end
    release_rsp();
  endtask

  task automatic test_napot_priority();
    int lat;
    clear_cfg();
    pmp_pmpcfg[5]  = '{lock: 1'b0, mode: PMP_MODE_NAPOT, execute: 1'b0, write: 1'b0, read: 1'b1};
    pmp_pmpaddr[5] = 32'h0000_07FF;
    pmp_pmpcfg[6]  = '{lock: 1'b0, mode: PMP_MODE_NA4, execute: 1'b0, write: 1'b1, read: 1'b1};
    pmp_pmpaddr[6] = 32'h0000_07FF;
    do_req(32'h0000_0100, 2'b01, 1'b0, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL napot_latency got=%0d exp=2", lat); end
    total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL napot_err got=%b exp=1", rsp_err); end
    total++; if (rsp_match !== 1'b1) begin bad++; $display("FAIL napot_match got=%b exp=1", rsp_match); end
    total++; if (rsp_entry !== 6'd5) begin bad++; $display("FAIL napot_entry got=%0d exp=5", rsp_entry); end
    release_rsp();
  endtask

  task automatic test_no_match();
    int lat;
    clear_cfg();
    do_req(32'h0000_1234, 2'b10, 1'b1, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL nomatch_m_latency got=%0d exp=4", lat); end
    total++; if ({rsp_err, rsp_match} !== 2'b00) begin bad++; $display("FAIL nomatch_m_err_match got=%b exp=00", {rsp_err, rsp_match}); end
    total++; if (rsp_entry !== 6'd0) begin bad++; $display("FAIL nomatch_m_entry got=%0d exp=0", rsp_entry); end
    release_rsp();
    do_req(32'h0000_1234, 2'b00, 1'b0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL nomatch_u_latency got=%0d exp=4", lat); end
    total++; if ({rsp_err, rsp_match} !== 2'b10) begin bad++; $display("FAIL nomatch_u_err_match got=%b exp=10", {rsp_err, rsp_match}); end
    release_rsp();
  endtask

  task automatic test_lock();
    int lat;
    clear_cfg();
    pmp_pmpcfg[3]  = '{lock: 1'b1, mode: PMP_MODE_NA4, execute: 1'b0, write: 1'b0, read: 1'b1};
    pmp_pmpaddr[3] = 32'h0000_0100;
    do_req(32'h0000_0400, 2'b10, 1'b1, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL lock_latency got=%0d exp=1", lat); end
    total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL lock_err got=%b exp=1", rsp_err); end
    total++; if (rsp_entry !== 6'd3) begin bad++; $display("FAIL lock_entry got=%0d exp=3", rsp_entry); end
    release_rsp();
    pmp_pmpcfg[3].lock = 1'b0;
    do_req(32'h0000_0400, 2'b10, 1'b1, lat);
    total++; if ({rsp_err, rsp_match, rsp_entry} !== {1'b0, 1'b1, 6'd3}) begin bad++;
      $display("FAIL unlock_rsp got=%b/%b/%0d exp=0/1/3", rsp_err, rsp_match, rsp_entry); end
    release_rsp();
    pmp_pmpcfg[3] = '{lock: 1'b0, mode: PMP_MODE_NA4, execute: 1'b1, write: 1'b1, read: 1'b1};
    do_req(32'h0000_0400, 2'b11, 1'b0, lat);
    total++; if ({rsp_err, rsp_entry} !== {1'b1, 6'd3}) begin bad++;
      $display("FAIL type11_rsp got=%b/%0d exp=1/3", rsp_err, rsp_entry); end
    release_rsp();
  endtask

  task automatic test_restart();
    int lat;
    clear_cfg();
    req_valid = 1'b1; req_addr = 32'h0000_4000; req_type = 2'b00; req_priv = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    // Second SCAN cycle: reprogram entry 13 and pulse the CSR-write strobe.
    pmp_cfg_wr      = 1'b1;
    pmp_pmpcfg[13]  = '{lock: 1'b0, mode: PMP_MODE_NA4, execute: 1'b0, write: 1'b0, read: 1'b0};
    pmp_pmpaddr[13] = 32'h0000_1000;
    @(posedge clk); #1;
    pmp_cfg_wr = 1'b0;
    lat = 2;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat !== 6) begin bad++; $display("FAIL restart_latency got=%0d exp=6", lat); end
    total++; if ({rsp_err, rsp_match, rsp_entry} !== {1'b1, 1'b1, 6'd13}) begin bad++;
      $display("FAIL restart_rsp got=%b/%b/%0d exp=1/1/13", rsp_err, rsp_match, rsp_entry); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_err, rsp_match, rsp_entry, req_ready} !== {1'b1, 1'b1, 1'b1, 6'd13, 1'b0}) begin bad++;
        $display("FAIL stall_hold cyc=%0d got=%b%b%b/%0d/%b exp=111/13/0", i, rsp_valid, rsp_err, rsp_match, rsp_entry, req_ready);
      end
      if (i == 1) begin
        clear_cfg();
        pmp_cfg_wr = 1'b1;
      end
      @(posedge clk); #1;
      pmp_cfg_wr = 1'b0;
    end
    release_rsp();
    total++; if ({req_ready, rsp_valid} !== 2'b10) begin bad++;
      $display("FAIL release_state got=%b exp=10", {req_ready, rsp_valid}); end
  endtask

  task automatic test_reset_mid();
    logic spur;
    clear_cfg();
    req_valid = 1'b1; req_addr = 32'h0000_0040; req_type = 2'b10; req_priv = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_l = 1'b0;
    #1;
    total++; if ({req_ready, rsp_valid, rsp_err, rsp_match, rsp_entry} !== {4'b1000, 6'd0}) begin bad++;
      $display("FAIL midreset_outputs got=%b%b%b%b/%0d exp=1000/0", req_ready, rsp_valid, rsp_err, rsp_match, rsp_entry); end
    @(posedge clk); #4;
    rst_l = 1'b1;
    spur = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) spur = 1'b1;
    end
    total++; if (spur !== 1'b0) begin bad++; $display("FAIL midreset_spurious got=%b exp=0", spur); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midreset_req_ready got=%b exp=1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_tor();
    test_napot_priority();
    test_no_match();
    test_lock();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
